// File: rtl/gcm_stream_sequencer_pkg.sv
// Shared encodings for the GCM stream sequencer: FSM states, host word kinds
// and the layout of the closing len(A)||len(C) block.
package gcm_stream_sequencer_pkg;

    localparam int WORD_W     = 128;
    localparam int WORD_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        AAD      = 3'd1,
        DATA     = 3'd2,
        EMPTY    = 3'd3,
        LEN      = 3'd4,
        WAIT_TAG = 3'd5
    } seq_state_t;

    localparam logic KIND_AAD  = 1'b0;
    localparam logic KIND_DATA = 1'b1;

    // len(A) sits in the upper half of the closing block, len(C) in the lower half.
    function automatic logic [WORD_W-1:0] len_block(input logic [63:0] a_bits,
                                                    input logic [63:0] c_bits);
        return {a_bits, c_bits};
    endfunction

endpackage

// File: rtl/gcm_byte_mask.sv
// Zeroes bytes nbytes..15 of a 128-bit word (byte 0 in the MSBs); purely combinational,
// shared by the AAD and DATA paths.
module gcm_byte_mask
    import gcm_stream_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] data,
    input  logic [4:0]        nbytes,
    output logic [WORD_W-1:0] masked
);

    always_comb begin
        masked = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (5'(i) < nbytes) begin
                masked[WORD_W-1-8*i -: 8] = data[WORD_W-1-8*i -: 8];
            end
        end
    end

endmodule

// File: rtl/gcm_stream_sequencer.sv
// AES-GCM core feeder: accepted host word appears as a core strobe one cycle later; host is stalled
// while the core is not ready or within two cycles of any strobe. Byte limits only with GCM_SEQ_LIMIT_EN.
module gcm_stream_sequencer
    import gcm_stream_sequencer_pkg::*;
#(
    parameter int LEN_W = 64,
    parameter logic [63:0] MAX_C_BYTES = 64'd68719476704,
    parameter logic [63:0] MAX_A_BYTES = 64'h1FFF_FFFF_FFFF_FFFF
)(
    input  logic              iClk,
    input  logic              iRstn,
    input  logic              iStart,
    input  logic              iNoAad,
    input  logic              iNoData,
    input  logic [WORD_W-1:0] iS_data,
    input  logic              iS_kind,
    input  logic              iS_last,
    input  logic [4:0]        iS_nbytes,
    input  logic              iS_valid,
    output logic              oS_ready,
    output logic              oCore_init,
    output logic [WORD_W-1:0] oCore_aad,
    output logic              oCore_aad_valid,
    output logic              oCore_aad_last,
    output logic [WORD_W-1:0] oCore_blk,
    output logic              oCore_blk_valid,
    output logic              oCore_blk_last,
    input  logic              iCore_ready,
    input  logic              iCore_tag_valid,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr
);

    seq_state_t        state, state_nxt;
    logic              no_data;
    logic              hold_q, hold;
    logic [WORD_W-1:0] aad_dat, blk_dat, masked;
    logic              aad_vld, aad_last, blk_vld, blk_last;
    logic [LEN_W-1:0]  a_bits, c_bits, add_bits;
    logic              err_q;
    logic              in_stream, kind_ok, bad_len, over, base_rdy, accept, proto_err, core_go;
    logic              len_fire, empty_fire;
    logic [4:0]        nbytes_eff;

    // Hold covers the strobe cycle and the one after it, giving a 2-cycle gap between strobes.
    assign hold       = hold_q | aad_vld | blk_vld | blk_last;
    assign core_go    = iCore_ready & ~hold;
    assign in_stream  = (state == AAD) || (state == DATA);
    assign kind_ok    = iS_kind == ((state == DATA) ? KIND_DATA : KIND_AAD);
    assign nbytes_eff = iS_last ? iS_nbytes : 5'(WORD_BYTES);
    assign bad_len    = iS_last & ((iS_nbytes == 5'd0) | (iS_nbytes > 5'(WORD_BYTES)));
    assign add_bits   = LEN_W'({nbytes_eff, 3'b000});

`ifdef GCM_SEQ_LIMIT_EN
    localparam logic [LEN_W:0] A_LIM = (LEN_W+1)'(MAX_A_BYTES) << 3;
    localparam logic [LEN_W:0] C_LIM = (LEN_W+1)'(MAX_C_BYTES) << 3;
    logic [LEN_W:0] cnt_sum;
    assign cnt_sum = {1'b0, (state == DATA) ? c_bits : a_bits} + (LEN_W+1)'(add_bits);
    assign over    = kind_ok & (cnt_sum > ((state == DATA) ? C_LIM : A_LIM));
`else
    assign over = 1'b0;
`endif

    assign base_rdy  = in_stream & core_go & kind_ok;
    assign oS_ready  = base_rdy & ~over;
    assign accept    = iS_valid & oS_ready & ~bad_len;
    assign proto_err = in_stream & iS_valid & (~kind_ok | bad_len | over);

    gcm_byte_mask u_mask (
        .data   (iS_data),
        .nbytes (nbytes_eff),
        .masked (masked)
    );

    always_ff @(posedge iClk) begin
        if (!iRstn) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        len_fire   = 1'b0;
        empty_fire = 1'b0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    if (!iNoAad)      state_nxt = AAD;
                    else if (iNoData) state_nxt = EMPTY;
                    else              state_nxt = DATA;
                end
            end
            AAD:      if (accept && iS_last) state_nxt = no_data ? EMPTY : DATA;
            DATA:     if (accept && iS_last) state_nxt = LEN;
            EMPTY: begin
                if (core_go) begin
                    empty_fire = 1'b1;
                    state_nxt  = LEN;
                end
            end
            LEN: begin
                if (core_go) begin
                    len_fire  = 1'b1;
                    state_nxt = WAIT_TAG;
                end
            end
            WAIT_TAG: if (iCore_tag_valid) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (proto_err) state_nxt = IDLE;
    end

    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            no_data  <= 1'b0;
            hold_q   <= 1'b0;
            aad_dat  <= '0;
            blk_dat  <= '0;
            aad_vld  <= 1'b0;
            aad_last <= 1'b0;
            blk_vld  <= 1'b0;
            blk_last <= 1'b0;
            a_bits   <= '0;
            c_bits   <= '0;
            err_q    <= 1'b0;
        end else begin
            hold_q   <= aad_vld | blk_vld | blk_last;
            aad_vld  <= 1'b0;
            aad_last <= 1'b0;
            blk_vld  <= 1'b0;
            blk_last <= 1'b0;
            if (state == IDLE && iStart) begin
                no_data <= iNoData;
                a_bits  <= '0;
                c_bits  <= '0;
                err_q   <= 1'b0;
            end
            if (proto_err) err_q <= 1'b1;
            if (accept && state == AAD) begin
                aad_dat  <= masked;
                aad_vld  <= 1'b1;
                aad_last <= iS_last;
                a_bits   <= a_bits + add_bits;
            end
            if (accept && state == DATA) begin
                blk_dat  <= masked;
                blk_vld  <= 1'b1;
                blk_last <= iS_last;
                c_bits   <= c_bits + add_bits;
            end
            if (empty_fire) blk_last <= 1'b1;
            if (len_fire) begin
                aad_dat <= len_block(a_bits, c_bits);
                aad_vld <= 1'b1;
            end
        end
    end

    assign oCore_aad       = aad_dat;
    assign oCore_aad_valid = aad_vld;
    assign oCore_aad_last  = aad_last;
    assign oCore_blk       = blk_dat;
    assign oCore_blk_valid = blk_vld;
    assign oCore_blk_last  = blk_last;
    assign oBusy           = state != IDLE;
    assign oCore_init      = state != IDLE;
    assign oDone           = (state == WAIT_TAG) & iCore_tag_valid;
    assign oErr            = err_q;

endmodule

// File: tb/tb_gcm_stream_sequencer.sv
// Scoreboard bench for gcm_stream_sequencer: expected core strobes are queued as host words are driven.
module tb_gcm_stream_sequencer;

    typedef struct {
        logic [1:0]   typ;   // 0 aad strobe, 1 blk strobe, 2 lone blk_last
        logic         last;
        logic [127:0] dat;
    } ev_t;

`ifdef GCM_SEQ_LIMIT_EN
    localparam logic [63:0] TB_MAX_C_BYTES = 64'd32;
`else
    localparam logic [63:0] TB_MAX_C_BYTES = 64'd68719476704;
`endif

    logic         clk = 1'b0;
    logic         rstn, start, no_aad, no_data;
    logic [127:0] s_data;
    logic         s_kind, s_last, s_valid;
    logic [4:0]   s_nbytes;
    logic         s_ready, core_init, aad_valid, aad_last, blk_valid, blk_last;
    logic [127:0] core_aad, core_blk;
    logic         core_ready, tag_valid, busy, done, err;

    ev_t exp_q[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  prev_stb = -100;
    int  blk_seen = 0;

    always #5 clk = ~clk;

    gcm_stream_sequencer #(.MAX_C_BYTES(TB_MAX_C_BYTES)) dut (
        .iClk            (clk),
        .iRstn           (rstn),
        .iStart          (start),
        .iNoAad          (no_aad),
        .iNoData         (no_data),
        .iS_data         (s_data),
        .iS_kind         (s_kind),
        .iS_last         (s_last),
        .iS_nbytes       (s_nbytes),
        .iS_valid        (s_valid),
        .oS_ready        (s_ready),
        .oCore_init      (core_init),
        .oCore_aad       (core_aad),
        .oCore_aad_valid (aad_valid),
        .oCore_aad_last  (aad_last),
        .oCore_blk       (core_blk),
        .oCore_blk_valid (blk_valid),
        .oCore_blk_last  (blk_last),
        .iCore_ready     (core_ready),
        .iCore_tag_valid (tag_valid),
        .oBusy           (busy),
        .oDone           (done),
        .oErr            (err)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] mask_model(input logic [127:0] d, input int nb);
        logic [127:0] tail;
        tail = {128{1'b1}} >> (8 * nb);
        return d & ~tail;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: every core strobe is matched against the queue head.
    always @(negedge clk) begin : monitor
        ev_t e, g;
        if (!rstn) begin
            prev_stb <= -100;
        end else if (aad_valid || blk_valid || blk_last) begin
            g.typ  = aad_valid ? 2'd0 : (blk_valid ? 2'd1 : 2'd2);
            g.last = aad_valid ? aad_last : blk_last;
            g.dat  = aad_valid ? core_aad : core_blk;
            if (blk_valid) blk_seen <= blk_seen + 1;
            chk("strobe_gap", 128'((cyc - prev_stb) >= 3), 128'd1);
            prev_stb <= cyc;
            chk("q_nonempty", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("ev_typ", 128'(g.typ), 128'(e.typ));
                chk("ev_last", 128'(g.last), 128'(e.last));
                if (e.typ != 2'd2) chk("ev_dat", g.dat, e.dat);
            end
        end
    end

    task automatic push_ev(input logic [1:0] typ, input logic last, input logic [127:0] dat);
        ev_t e;
        e.typ  = typ;
        e.last = last;
        e.dat  = dat;
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic kind, input logic last, input logic [4:0] nb,
                             input logic [127:0] dat);
        int n;
        push_ev(kind ? 2'd1 : 2'd0, last, mask_model(dat, last ? int'(nb) : 16));
        @(posedge clk); #1;
        s_valid = 1'b1; s_kind = kind; s_last = last; s_nbytes = nb; s_data = dat;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 128'(n), 128'd0);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic start_msg(input logic na, input logic nd);
        @(posedge clk); #1;
        start = 1'b1; no_aad = na; no_data = nd;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_busy", 128'(busy), 128'd1);
        chk("start_init", 128'(core_init), 128'd1);
        chk("start_err_clr", 128'(err), 128'd0);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk(tag, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic stream_kind(input logic kind, input int nbytes);
        int rem;
        int nb;
        rem = nbytes;
        while (rem > 0) begin
            nb = (rem > 16) ? 16 : rem;
            send_word(kind, rem <= 16, 5'(nb), rand128());
            rem -= nb;
        end
    endtask

    task automatic run_msg(input logic na, input logic nd, input int a_bytes, input int c_bytes);
        logic [63:0] la, lc;
        la = 64'(a_bytes) << 3;
        lc = 64'(c_bytes) << 3;
        start_msg(na, nd);
        if (!na) stream_kind(1'b0, a_bytes);
        if (nd) push_ev(2'd2, 1'b1, 128'd0);
        else    stream_kind(1'b1, c_bytes);
        push_ev(2'd0, 1'b0, {la, lc});
        wait_drain("len_drain");
        chk("init_before_tag", 128'(core_init), 128'd1);
        @(posedge clk); #1;
        tag_valid = 1'b1;
        @(negedge clk);
        chk("done_on_tag", 128'(done), 128'd1);
        @(posedge clk); #1;
        tag_valid = 1'b0;
        @(negedge clk);
        chk("idle_after_tag", 128'({busy, done, core_init}), 128'd0);
    endtask

    task automatic inject_bad(input logic kind, input logic last, input logic [4:0] nb, input string tag);
        @(posedge clk); #1;
        s_valid = 1'b1; s_kind = kind; s_last = last; s_nbytes = nb; s_data = rand128();
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_err"}, 128'(err), 128'd1);
        chk({tag, "_busy_init"}, 128'({busy, core_init}), 128'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_err_sticky"}, 128'(err), 128'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; start = 1'b1; no_aad = 1'b0; no_data = 1'b0;
        s_data = '0; s_kind = 1'b0; s_last = 1'b0; s_nbytes = 5'd0; s_valid = 1'b0;
        core_ready = 1'b1; tag_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 128'({s_ready, core_init, aad_valid, aad_last, blk_valid, blk_last, busy, done, err}), 128'd0);
        chk("rst_aad", core_aad, 128'd0);
        chk("rst_blk", core_blk, 128'd0);
        @(posedge clk); #1;
        start = 1'b0; rstn = 1'b1;
        @(negedge clk);
        chk("rst_start_ignored", 128'(busy), 128'd0);

        // AAD 20B + DATA 32B: len = 0xA0 || 0x100
        run_msg(1'b0, 1'b0, 20, 32);
        // DATA only, 17B: last word keeps byte 0 only, len = 0 || 0x88
        run_msg(1'b1, 1'b0, 0, 17);
        // empty message: lone blk_last then len 0||0
        run_msg(1'b1, 1'b1, 0, 0);
        // AAD then no DATA
        run_msg(1'b0, 1'b1, 5, 0);

        // wrong kind while in DATA
        start_msg(1'b1, 1'b0);
        send_word(1'b1, 1'b0, 5'd16, rand128());
        wait_drain("kind_drain");
        inject_bad(1'b0, 1'b0, 5'd16, "kind");
        // bad nbytes on a last word
        start_msg(1'b0, 1'b0);
        inject_bad(1'b0, 1'b1, 5'd0, "nb0");
        start_msg(1'b1, 1'b0);
        inject_bad(1'b1, 1'b1, 5'd17, "nb17");

        // core not ready for 10 cycles mid-DATA
        fork
            run_msg(1'b0, 1'b0, 48, 32);
            begin
                int base;
                int n;
                base = blk_seen;
                n = 0;
                while (blk_seen == base && n < 500) begin
                    @(posedge clk);
                    n++;
                end
                chk("stall_found_blk", 128'(blk_seen > base), 128'd1);
                #1 core_ready = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("stall_rdy", 128'(s_ready), 128'd0);
                    if (i > 0) chk("stall_no_strobe", 128'({aad_valid, blk_valid}), 128'd0);
                end
                @(posedge clk); #1;
                core_ready = 1'b1;
            end
        join

        // reset mid-message: no len block afterwards
        start_msg(1'b0, 1'b0);
        send_word(1'b0, 1'b0, 5'd16, rand128());
        wait_drain("rst_mid_drain");
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 128'({busy, core_init}), 128'd0);
        chk("rst_mid_aad", core_aad, 128'd0);
        repeat (20) @(negedge clk);

`ifdef GCM_SEQ_LIMIT_EN
        // third 16B DATA word crosses the 32-byte limit
        start_msg(1'b1, 1'b0);
        send_word(1'b1, 1'b0, 5'd16, rand128());
        send_word(1'b1, 1'b0, 5'd16, rand128());
        wait_drain("lim_drain");
        repeat (4) @(posedge clk);
        #1;
        s_valid = 1'b1; s_kind = 1'b1; s_last = 1'b0; s_nbytes = 5'd16; s_data = rand128();
        @(negedge clk);
        chk("lim_rdy", 128'(s_ready), 128'd0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("lim_err", 128'(err), 128'd1);
        chk("lim_busy", 128'(busy), 128'd0);
        repeat (20) @(negedge clk);
`endif

        chk("final_q_empty", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
